// File: rtl/ethpipe_pkg.sv
// Shared constants and types for the ethpipe receive path.
package ethpipe_pkg;

    localparam int         PTR_W     = 12;
    localparam int         HDR_WORDS = 4;
    localparam logic [7:0] PREAMBLE  = 8'h55;
    localparam logic [7:0] SFD       = 8'hD5;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        HDR,
        DROP
    } rx_state_e;

endpackage

// File: rtl/rx_byte_packer.sv
// Packs GMII bytes into 16-bit words, big-endian within the word; flush emits
// a held odd byte padded with 0x00.
module rx_byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    input  logic        flush_i,
    output logic        word_vld_o,
    output logic [15:0] word_o
);

    logic       have_q, have_d;
    logic [7:0] hold_q, hold_d;

    always_comb begin
        have_d = have_q;
        hold_d = hold_q;
        if (clr_i) begin
            have_d = 1'b0;
        end else if (byte_vld_i) begin
            have_d = !have_q;
            if (!have_q)
                hold_d = byte_i;
        end else if (flush_i) begin
            have_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            have_q <= 1'b0;
            hold_q <= 8'h00;
        end else begin
            have_q <= have_d;
            hold_q <= hold_d;
        end
    end

    assign word_vld_o = have_q && !clr_i && (byte_vld_i || flush_i);
    assign word_o     = {hold_q, byte_vld_i ? byte_i : 8'h00};

endmodule

// File: rtl/rx_gmii_framer.sv
// GMII receive framer: writes timestamped length-prefixed records into a circular
// word buffer. Define ETHPIPE_RX_DROP_CNT_EN to add the drop_cnt port and counter.
module rx_gmii_framer
    import ethpipe_pkg::*;
#(
    parameter int MAX_LEN = 1536,
    parameter int MIN_LEN = 64
) (
    input  logic        clk_125,
    input  logic        sys_rst,
    input  logic [47:0] global_counter,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    input  logic [11:0] rxmem_rd_ptr,
    output logic        rxmem_wr_en,
    output logic [11:0] rxmem_wr_addr,
    output logic [15:0] rxmem_wr_data,
    output logic [11:0] rxmem_wr_ptr,
`ifdef ETHPIPE_RX_DROP_CNT_EN
    output logic        rx_frame_done,
    output logic [31:0] drop_cnt
`else
    output logic        rx_frame_done
`endif
);

    rx_state_e        state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [47:0]      ts_q, ts_d;
    logic [1:0]       hidx_q, hidx_d;
    logic             late_q, late_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             en_q, en_d;
    logic [PTR_W-1:0] addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             done_q, done_d;

    logic [PTR_W-1:0] free_words, pay_addr, rec_words;
    logic [16:0]      cnt_nx, need;
    logic             oversize, nospace;
    logic             pk_vld, pk_flush, pk_clr, pk_word_vld;
    logic [15:0]      pk_word;

    // The committed write pointer doubles as the base of the record in flight.
    assign free_words = rxmem_rd_ptr - ptr_q - 12'd1;
    assign cnt_nx     = {1'b0, cnt_q} + 17'd1;
    assign need       = 17'(HDR_WORDS) + ((cnt_nx + 17'd1) >> 1);
    assign oversize   = cnt_nx > 17'(MAX_LEN);
    assign nospace    = need > {5'b0, free_words};
    assign pay_addr   = ptr_q + 12'(HDR_WORDS) + cnt_q[12:1];
    assign rec_words  = 12'(HDR_WORDS) + 12'((cnt_q + 16'd1) >> 1);

    assign pk_vld   = (state_q == DATA) && gmii_rx_dv && !oversize && !nospace;
    assign pk_flush = (state_q == DATA) && !gmii_rx_dv;
    assign pk_clr   = (state_q != DATA);

    rx_byte_packer u_packer (
        .clk_i      (clk_125),
        .rst_i      (sys_rst),
        .clr_i      (pk_clr),
        .byte_vld_i (pk_vld),
        .byte_i     (gmii_rxd),
        .flush_i    (pk_flush),
        .word_vld_o (pk_word_vld),
        .word_o     (pk_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        hidx_d  = hidx_q;
        late_d  = late_q;
        ptr_d   = ptr_q;
        en_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (pk_word_vld) begin
            en_d   = 1'b1;
            addr_d = pay_addr;
            data_d = pk_word;
        end

        case (state_q)
            IDLE: if (gmii_rx_dv && gmii_rxd == PREAMBLE) state_d = PRE;
            PRE: begin
                if (gmii_rx_dv && gmii_rxd == SFD) begin
                    state_d = DATA;
                    ts_d    = global_counter;
                    cnt_d   = 16'd0;
                end else if (!(gmii_rx_dv && gmii_rxd == PREAMBLE)) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!gmii_rx_dv) begin
                    state_d = HDR;
                    hidx_d  = 2'd0;
                    late_d  = 1'b0;
                end else if (oversize || nospace) begin
                    state_d = DROP;
                end else begin
                    cnt_d = cnt_nx[15:0];
                end
            end
            HDR: begin
                // A frame starting during header writeout cannot be framed; drop it whole.
                late_d = late_q | gmii_rx_dv;
                if (cnt_q < 16'(MIN_LEN)) begin
                    state_d = DROP;
                end else begin
                    en_d   = 1'b1;
                    addr_d = ptr_q + {10'b0, hidx_q};
                    case (hidx_q)
                        2'd0:    data_d = cnt_q;
                        2'd1:    data_d = ts_q[47:32];
                        2'd2:    data_d = ts_q[31:16];
                        default: data_d = ts_q[15:0];
                    endcase
                    hidx_d = hidx_q + 2'd1;
                    if (hidx_q == 2'd3) begin
                        ptr_d   = ptr_q + rec_words;
                        done_d  = 1'b1;
                        state_d = (late_q || gmii_rx_dv) ? DROP : IDLE;
                    end
                end
            end
            DROP:    if (!gmii_rx_dv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            ts_q    <= 48'd0;
            hidx_q  <= 2'd0;
            late_q  <= 1'b0;
            ptr_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            hidx_q  <= hidx_d;
            late_q  <= late_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign rxmem_wr_en   = en_q;
    assign rxmem_wr_addr = addr_q;
    assign rxmem_wr_data = data_q;
    assign rxmem_wr_ptr  = ptr_q;
    assign rx_frame_done = done_q;

`ifdef ETHPIPE_RX_DROP_CNT_EN
    logic [31:0] drop_q;

    always_ff @(posedge clk_125) begin
        if (sys_rst)
            drop_q <= 32'd0;
        else if (state_d == DROP && state_q != DROP && drop_q != 32'hFFFF_FFFF)
            drop_q <= drop_q + 32'd1;
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_rx_gmii_framer.sv
// Directed bench for rx_gmii_framer: records captured into a shadow buffer.
`timescale 1ns/1ps
module tb_rx_gmii_framer;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [47:0] gc;
    logic        dv;
    logic [7:0]  rxd;
    logic [11:0] rd_ptr;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [11:0] wr_ptr;
    logic        done;
`ifdef ETHPIPE_RX_DROP_CNT_EN
    logic [31:0] drop_cnt;
`endif

    logic [15:0] mem [0:4095];
    logic        mem_clr;
    int          done_cnt = 0;
    int          nvec = 0;
    int          nerr = 0;

    always #4 clk = ~clk;

    rx_gmii_framer dut (
        .clk_125        (clk),
        .sys_rst        (sys_rst),
        .global_counter (gc),
        .gmii_rx_dv     (dv),
        .gmii_rxd       (rxd),
        .rxmem_rd_ptr   (rd_ptr),
        .rxmem_wr_en    (wr_en),
        .rxmem_wr_addr  (wr_addr),
        .rxmem_wr_data  (wr_data),
        .rxmem_wr_ptr   (wr_ptr),
`ifdef ETHPIPE_RX_DROP_CNT_EN
        .rx_frame_done  (done),
        .drop_cnt       (drop_cnt)
`else
        .rx_frame_done  (done)
`endif
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'hDEAD;
        end else if (wr_en === 1'b1) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected summary before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_wr_en"}, {47'd0, wr_en}, 48'd0);
        check({tag, "_wr_addr"}, {36'd0, wr_addr}, 48'd0);
        check({tag, "_wr_data"}, {32'd0, wr_data}, 48'd0);
        check({tag, "_wr_ptr"}, {36'd0, wr_ptr}, 48'd0);
        check({tag, "_done"}, {47'd0, done}, 48'd0);
`ifdef ETHPIPE_RX_DROP_CNT_EN
        check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 48'd0);
`endif
    endtask

    // Preamble, SFD (ts on global_counter), n bytes counting up from start.
    // chk: verify the first payload word appears one cycle after byte 1.
    // rst_at >= 0: pulse reset before data byte rst_at and abandon the frame.
    task automatic send_frame(input int n, input logic [7:0] start, input logic [47:0] ts,
                              input bit chk, input logic [11:0] base, input int rst_at);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); dv = 1'b1; rxd = 8'h55;
        end
        @(negedge clk); rxd = 8'hD5; gc = ts;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) gc = ts + 48'h111;
            if (chk && i == 2) begin
                check("pair_wr_en", {47'd0, wr_en}, 48'd1);
                check("pair_wr_addr", {36'd0, wr_addr}, {36'd0, base + 12'd4});
                check("pair_wr_data", {32'd0, wr_data}, {32'd0, start, start + 8'd1});
            end
            if (i == rst_at) begin
                sys_rst = 1'b1; dv = 1'b0; rxd = 8'h00;
                @(negedge clk);
                check_rst_outputs("midrst");
                sys_rst = 1'b0;
                repeat (4) @(negedge clk);
                return;
            end
            rxd = start + 8'(i);
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [11:0] exp_ptr;
        int          len;
        sys_rst = 1'b1; mem_clr = 1'b1; dv = 1'b0; rxd = 8'h00; gc = 48'd0; rd_ptr = 12'd0;
        repeat (3) @(negedge clk);
        check_rst_outputs("reset");
        sys_rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        // 64-byte frame at base 0
        send_frame(64, 8'h00, 48'h2000, 1'b1, 12'h000, -1);
        for (int k = 0; k < 32; k++)
            check("f64_payload", {32'd0, mem[4 + k]}, {32'd0, 8'(2 * k), 8'(2 * k + 1)});
        check("f64_w0", {32'd0, mem[0]}, 48'h0040);
        check("f64_w1", {32'd0, mem[1]}, 48'h0000);
        check("f64_w2", {32'd0, mem[2]}, 48'h0000);
        check("f64_w3", {32'd0, mem[3]}, 48'h2000);
        check("f64_ptr", {36'd0, wr_ptr}, 48'h024);
        check("f64_done", 48'(done_cnt), 48'd1);

        // 65-byte frame: odd byte padded
        rd_ptr = 12'h024;
        send_frame(65, 8'h00, 48'h0000_0001_0002, 1'b0, 12'h024, -1);
        check("f65_last", {32'd0, mem[12'h048]}, 48'h4000);
        check("f65_prev", {32'd0, mem[12'h047]}, 48'h3E3F);
        check("f65_w0", {32'd0, mem[12'h024]}, 48'h0041);
        check("f65_ptr", {36'd0, wr_ptr}, 48'h049);
        check("f65_done", 48'(done_cnt), 48'd2);

        // Fill to base 0xFFE; MAX_LEN-sized frames must be accepted
        exp_ptr = 12'h049;
        for (int f = 0; f < 6; f++) begin
            len = (f < 5) ? 1536 : 313;
            rd_ptr = exp_ptr;
            send_frame(len, 8'(f), 48'(f), 1'b0, exp_ptr, -1);
            exp_ptr = exp_ptr + 12'(4 + (len + 1) / 2);
            check("fill_ptr", {36'd0, wr_ptr}, {36'd0, exp_ptr});
        end
        check("fill_base", {36'd0, wr_ptr}, 48'hFFE);

        // Record straddling the buffer wrap
        rd_ptr = 12'hFFE;
        send_frame(64, 8'h10, 48'h1234_5678_9ABC, 1'b1, 12'hFFE, -1);
        check("wrap_w0", {32'd0, mem[12'hFFE]}, 48'h0040);
        check("wrap_w1", {32'd0, mem[12'hFFF]}, 48'h1234);
        check("wrap_w2", {32'd0, mem[12'h000]}, 48'h5678);
        check("wrap_w3", {32'd0, mem[12'h001]}, 48'h9ABC);
        check("wrap_p0", {32'd0, mem[12'h002]}, 48'h1011);
        check("wrap_plast", {32'd0, mem[12'h021]}, 48'h4E4F);
        check("wrap_ptr", {36'd0, wr_ptr}, 48'h022);
        check("wrap_done", 48'(done_cnt), 48'd9);

        // Runt then oversize
        rd_ptr = 12'h022;
        send_frame(60, 8'h20, 48'h5, 1'b0, 12'h022, -1);
        check("runt_ptr", {36'd0, wr_ptr}, 48'h022);
        send_frame(1600, 8'h30, 48'h6, 1'b0, 12'h022, -1);
        check("big_ptr", {36'd0, wr_ptr}, 48'h022);
        check("big_done", 48'(done_cnt), 48'd9);
`ifdef ETHPIPE_RX_DROP_CNT_EN
        check("big_drop_cnt", {16'd0, drop_cnt}, 48'd2);
`endif

        // Reset mid-frame, then a fresh frame lands at base 0
        send_frame(64, 8'h00, 48'h7, 1'b0, 12'h022, 30);
        rd_ptr = 12'h000;
        send_frame(64, 8'h80, 48'hABCD, 1'b0, 12'h000, -1);
        check("post_w0", {32'd0, mem[0]}, 48'h0040);
        check("post_w3", {32'd0, mem[3]}, 48'hABCD);
        check("post_p0", {32'd0, mem[4]}, 48'h8081);
        check("post_ptr", {36'd0, wr_ptr}, 48'h024);
        check("post_done", 48'(done_cnt), 48'd10);

        // Buffer full: 15 free words cannot hold a 64-byte record
        @(negedge clk); sys_rst = 1'b1; mem_clr = 1'b1;
        @(negedge clk); sys_rst = 1'b0; mem_clr = 1'b0;
        rd_ptr = 12'h010;
        send_frame(64, 8'h00, 48'h8, 1'b0, 12'h000, -1);
        check("full_ptr", {36'd0, wr_ptr}, 48'h000);
        check("full_done", 48'(done_cnt), 48'd10);
        check("full_nohdr", {32'd0, mem[0]}, 48'hDEAD);
        check("full_lastok", {32'd0, mem[14]}, 48'h1415);
        check("full_beyond", {32'd0, mem[15]}, 48'hDEAD);
`ifdef ETHPIPE_RX_DROP_CNT_EN
        check("full_drop_cnt", {16'd0, drop_cnt}, 48'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
